add_pipe: RTL and testbench

//  Parametrised, pipelined add/subtract unit. Successor to the fixed 16-bit chained-nibble adder.

---
 rtl/add_pipe_if.sv | 27 ++
 rtl/add_pipe.sv | 94 +++++++++
 tb/tb_add_pipe.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/add_pipe_if.sv
// Operand/result handshake bundle for the pipelined add/subtract unit.
// master drives operands and result ready; slave is the arithmetic unit.
interface add_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/add_pipe.sv
// Pipelined add/subtract: one SEG-bit segment per stage, carry registered between stages.
// Operands shift right each stage so the active segment is always in the low bits.
module add_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input logic       clk,
  input logic       rst_n,
  add_pipe_if.slave bus
);
  localparam int unsigned NSEG = WIDTH / SEG;
  localparam int unsigned SW   = SEG + 1;

  logic             en;

  logic [WIDTH-1:0] a_q [NSEG];
  logic [WIDTH-1:0] b_q [NSEG];
  logic [WIDTH-1:0] r_q [NSEG];
  logic [NSEG-1:0]  v_q;
  logic [NSEG-1:0]  c_q;
  logic             ovf_q;

  logic [WIDTH-1:0] a_in [NSEG];
  logic [WIDTH-1:0] b_in [NSEG];
  logic [WIDTH-1:0] r_in [NSEG];
  logic [WIDTH-1:0] r_d  [NSEG];
  logic [NSEG-1:0]  v_in;
  logic [NSEG-1:0]  c_in;
  logic [SEG:0]     s    [NSEG];
  logic             ovf_d;

  // Single global enable: the whole pipe moves unless a held result is blocked.
  assign en           = ~v_q[NSEG-1] | bus.out_ready;
  assign bus.in_ready = en;

  // Stage inputs: stage 0 takes the port operands, later stages take the previous stage.
  always_comb begin : stage_src
    a_in[0] = bus.a;
    b_in[0] = bus.sub ? ~bus.b : bus.b;
    c_in[0] = bus.sub | bus.cin;
    v_in[0] = bus.in_valid;
    r_in[0] = '0;
    for (int k = 1; k < int'(NSEG); k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
      r_in[k] = r_q[k-1];
    end
  end

  // Segment adders; each new result segment enters at the top and earlier ones shift down.
  always_comb begin : stage_add
    for (int k = 0; k < int'(NSEG); k++) begin
      s[k]   = {1'b0, a_in[k][SEG-1:0]} + {1'b0, b_in[k][SEG-1:0]} + SW'(c_in[k]);
      r_d[k] = (r_in[k] >> SEG) | (WIDTH'(s[k][SEG-1:0]) << (WIDTH - SEG));
    end
    // Same-sign operands giving a different-sign result == carry-in xor carry-out of the MSB.
    ovf_d = (a_in[NSEG-1][SEG-1] == b_in[NSEG-1][SEG-1]) &&
            (s[NSEG-1][SEG-1] != a_in[NSEG-1][SEG-1]);
  end

  // Data registers only load behind a valid token so outputs hold across bubbles.
  always_ff @(posedge clk) begin : stage_regs
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < int'(NSEG); k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
    end else if (en) begin
      v_q <= v_in;
      for (int k = 0; k < int'(NSEG); k++) begin
        if (v_in[k]) begin
          a_q[k] <= a_in[k] >> SEG;
          b_q[k] <= b_in[k] >> SEG;
          r_q[k] <= r_d[k];
          c_q[k] <= s[k][SEG];
        end
      end
      if (v_in[NSEG-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign bus.out_valid = v_q[NSEG-1];
  assign bus.sum       = r_q[NSEG-1];
  assign bus.cout      = c_q[NSEG-1];
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_add_pipe.sv
// Randomised and directed bench for add_pipe against an arithmetic reference model.
// Expected results are queued at accept time and compared whenever out_valid is high.
module tb_add_pipe;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned SEG   = 4;
  localparam int unsigned NSEG  = WIDTH / SEG;

  typedef logic [WIDTH+1:0] res_t;  // {ovf, cout, sum}

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  add_pipe_if #(.WIDTH(WIDTH)) bus ();

  add_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  res_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_in     = 0;
  int   n_out    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands as written.
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    int          sa;
    int          sb;
    int          sres;
    int unsigned ua;
    int unsigned ub;
    int unsigned full;
    logic [WIDTH-1:0] sm;
    logic        co;
    logic        ov;
    ua = 32'(a);
    ub = 32'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      sm   = WIDTH'(ua - ub);
      co   = (ua >= ub);
      sres = sa - sb;
    end else begin
      full = ua + ub + 32'(cin);
      sm   = WIDTH'(full);
      co   = (full >= 32'h1_0000);
      sres = sa + sb + int'(cin);
    end
    ov = (sres > 32767) || (sres < -32768);
    return {ov, co, sm};
  endfunction

  // One clock: drive at the falling edge, observe what the next rising edge will transfer.
  task automatic drive_cycle(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic c, input logic s, input logic ordy,
                             output logic acc, output logic got);
    @(negedge clk);
    bus.in_valid  = v;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = c;
    bus.sub       = s;
    bus.out_ready = ordy;
    #1;
    acc = v & bus.in_ready;
    got = bus.out_valid & ordy;
    if (ordy) check_val("in_ready_hi", 32'(bus.in_ready), 32'd1);
    else if (bus.out_valid) check_val("in_ready_stall", 32'(bus.in_ready), 32'd0);
    if (bus.out_valid) begin
      if (exp_q.size() == 0) check_val("spurious_out", 32'(bus.out_valid), 32'd0);
      else check_val("result", 32'({bus.ovf, bus.cout, bus.sum}), 32'(exp_q[0]));
    end
    if (got && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      n_out++;
    end
    if (acc) begin
      exp_q.push_back(model(a, b, c, s));
      n_in++;
    end
  endtask

  // Single op into an empty pipe; checks the literal result and the latency.
  task automatic directed(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic s, input logic [WIDTH-1:0] es,
                          input logic ec, input logic eo);
    logic acc;
    logic got;
    int   lat;
    lat = 0;
    drive_cycle(1'b1, a, b, c, s, 1'b1, acc, got);
    check_val({tag, "_acc"}, 32'(acc), 32'd1);
    for (int i = 1; i <= int'(NSEG) + 4 && lat == 0; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, got);
      if (got) begin
        lat = i;
        check_val({tag, "_sum"}, 32'(bus.sum), 32'(es));
        check_val({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        check_val({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
      end
    end
    check_val({tag, "_lat"}, 32'(lat), 32'(NSEG));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic             acc;
    logic             got;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    logic             rs;
    int               cnt;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_sum", 32'(bus.sum), 32'd0);
    check_val("rst_cout", 32'(bus.cout), 32'd0);
    check_val("rst_ovf", 32'(bus.ovf), 32'd0);
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    directed("add_carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("add_cin",   16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0);
    directed("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Back-to-back stream: every op accepted, results leave at one per cycle.
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
                  1'b1, acc, got);
      check_val("stream_acc", 32'(acc), 32'd1);
      if (got) cnt++;
    end
    for (int i = 0; i < int'(NSEG); i++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, got);
      if (got) cnt++;
    end
    check_val("stream_count", 32'(cnt), 32'd20);
    check_val("stream_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure window in the middle of a stream; an unaccepted op stays presented.
    ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom); rs = 1'($urandom);
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'b1, ra, rb, rc, rs, !(i >= 10 && i < 16), acc, got);
      if (i >= 10 && i < 16) check_val("stall_out_valid", 32'(bus.out_valid), 32'd1);
      if (acc) begin
        ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      end
    end
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, got);
    end
    check_val("bp_drain_empty", 32'(exp_q.size()), 32'd0);
    check_val("bp_in_eq_out", 32'(n_in), 32'(n_out));

    // Reset with three ops in flight and a fresh op presented during reset.
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
                  1'b1, acc, got);
    end
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = 16'h0F0F;
    bus.b        = 16'h0101;
    @(negedge clk);
    #1;
    check_val("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("mid_rst_sum", 32'(bus.sum), 32'd0);
    check_val("mid_rst_cout", 32'(bus.cout), 32'd0);
    check_val("mid_rst_ovf", 32'(bus.ovf), 32'd0);
    check_val("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    exp_q.delete();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, got);
      if (bus.out_valid) cnt++;
    end
    check_val("post_rst_stale", 32'(cnt), 32'd0);
    directed("post_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
